// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter: state and owner
// encodings used by the RTL and by debug tooling.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_I = 2'd1,
        ARB_WAIT_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_I    = 2'd1,
        OWNER_D    = 2'd2
    } arb_owner_e;

    // Maps the arbiter state to the requester that owns the outstanding access.
    function automatic arb_owner_e state_owner(input arb_state_e st);
        case (st)
            ARB_WAIT_I: return OWNER_I;
            ARB_WAIT_D: return OWNER_D;
            default:    return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch and data access. Data has
// fixed priority; one transaction is outstanding and the next may issue on
// the cycle its predecessor's response returns.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_data_valid,
    input  logic                  d_start,
    output logic                  d_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_wen,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_data_valid,
    output logic                  mem_start,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_data_valid
);

    arb_state_e state_r;
    arb_state_e state_next_s;
    logic       open_s;
    logic       grant_d_s;
    logic       grant_i_s;

    // Accept window: with an access outstanding, a new one may only issue as
    // the response arrives. Held shut while in reset.
    always_comb begin
        open_s = 1'b0;
        if (rst) begin
            open_s = 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE:               open_s = mem_ready;
                ARB_WAIT_I, ARB_WAIT_D: open_s = mem_data_valid && mem_ready;
                default:                open_s = 1'b0;
            endcase
        end
    end

    // Fixed-priority grant, data before fetch.
    always_comb begin
        grant_d_s = d_start && open_s;
        grant_i_s = i_start && open_s && !d_start;
    end

    // Request mux toward memory; idle bus is driven to zero.
    always_comb begin
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wen   = 1'b0;
        mem_wdata = {DATA_WIDTH{1'b0}};
        if (grant_d_s) begin
            mem_addr  = d_addr;
            mem_wen   = d_wen;
            mem_wdata = d_wdata;
        end else if (grant_i_s) begin
            mem_addr  = i_addr;
            mem_wen   = 1'b0;
            mem_wdata = {DATA_WIDTH{1'b0}};
        end else begin
            mem_addr  = {ADDR_WIDTH{1'b0}};
            mem_wen   = 1'b0;
            mem_wdata = {DATA_WIDTH{1'b0}};
        end
    end

    // Handshake and response routing; a response seen in IDLE matches no owner.
    always_comb begin
        mem_start    = grant_d_s || grant_i_s;
        d_ready      = open_s;
        i_ready      = open_s && !d_start;
        i_data_valid = !rst && mem_data_valid && (state_r == ARB_WAIT_I);
        d_data_valid = !rst && mem_data_valid && (state_r == ARB_WAIT_D);
        i_data       = mem_data;
        d_data       = mem_data;
    end

    // Next-state: a new grant wins over retiring to IDLE.
    always_comb begin
        state_next_s = state_r;
        if (grant_d_s) begin
            state_next_s = ARB_WAIT_D;
        end else if (grant_i_s) begin
            state_next_s = ARB_WAIT_I;
        end else begin
            case (state_r)
                ARB_IDLE:               state_next_s = ARB_IDLE;
                ARB_WAIT_I, ARB_WAIT_D: state_next_s = mem_data_valid ? ARB_IDLE : state_r;
                default:                state_next_s = ARB_IDLE;
            endcase
        end
    end

    // Single state register; the only storage in the arbiter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: per-cycle request-side checks plus a
// response scoreboard popped by an independent monitor.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam logic        H    = 1'b1;
    localparam logic        L    = 1'b0;
    localparam logic [31:0] Z    = 32'h0000_0000;
    localparam logic [31:0] WACK = 32'h0000_ACED;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_ready, i_data_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data;
    logic          d_start, d_ready, d_wen, d_data_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_data;
    logic          mem_start, mem_ready, mem_wen, mem_data_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_data;

    typedef struct packed {
        arb_owner_e    own;
        logic [DW-1:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       mon_e;
    arb_owner_e mon_own;
    logic [DW-1:0] mon_data;

    memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_ready(i_ready), .i_addr(i_addr),
        .i_data(i_data), .i_data_valid(i_data_valid),
        .d_start(d_start), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .d_data(d_data), .d_data_valid(d_data_valid),
        .mem_start(mem_start), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_data(mem_data),
        .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    // Read data the bench's memory returns for a given address.
    function automatic logic [31:0] mdat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic sb_push(input arb_owner_e own, input logic [31:0] data);
        exp_t e;
        e.own  = own;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs, check the request-side outputs at negedge.
    task automatic cyc(input string nm,
                       input logic is, input logic [31:0] ia,
                       input logic ds, input logic [31:0] da, input logic dw, input logic [31:0] dwd,
                       input logic mr, input logic mdv, input logic [31:0] md,
                       input logic e_ms, input logic [31:0] e_ma, input logic e_mw,
                       input logic [31:0] e_mwd, input logic e_ir, input logic e_dr);
        logic [67:0] act;
        logic [67:0] exp;
        i_start = is; i_addr = ia;
        d_start = ds; d_addr = da; d_wen = dw; d_wdata = dwd;
        mem_ready = mr; mem_data_valid = mdv; mem_data = md;
        exp = {e_ms, e_ma, e_mw, e_mwd, e_ir, e_dr};
        @(negedge clk);
        act = {mem_start, mem_addr, mem_wen, mem_wdata, i_ready, d_ready};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got start=%0b addr=%h wen=%0b wdata=%h i_rdy=%0b d_rdy=%0b, want start=%0b addr=%h wen=%0b wdata=%h i_rdy=%0b d_rdy=%0b",
                     nm, act[67], act[66:35], act[34], act[33:2], act[1], act[0],
                     e_ms, e_ma, e_mw, e_mwd, e_ir, e_dr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string nm, input arb_state_e e);
        n_checks++;
        if (dut.state_r !== e) begin
            n_fail++;
            $display("FAIL %s: state got %0d want %0d", nm, dut.state_r, e);
        end
    endtask

    // Response monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (i_data_valid || d_data_valid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: i_valid=%0b d_valid=%0b with nothing outstanding",
                         i_data_valid, d_data_valid);
            end else begin
                mon_e = sb_q.pop_front();
                if (i_data_valid && d_data_valid) begin
                    mon_own  = OWNER_NONE;
                    mon_data = Z;
                end else if (i_data_valid) begin
                    mon_own  = OWNER_I;
                    mon_data = i_data;
                end else begin
                    mon_own  = OWNER_D;
                    mon_data = d_data;
                end
                if (mon_own !== mon_e.own || mon_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL response: got owner=%0d data=%h want owner=%0d data=%h",
                             mon_own, mon_data, mon_e.own, mon_e.data);
                end
            end
        end
    end

    initial begin
        rst = H;
        cyc("rst_hold", H, 32'h100, H, 32'h2000, H, 32'h1, H, H, 32'h77, L, Z, L, Z, L, L);
        check_state("rst_state", ARB_IDLE);
        rst = L;

        // lone fetch, latency 2
        sb_push(OWNER_I, mdat(32'h100));
        cyc("fetch_issue", H, 32'h100, L, Z, L, Z, H, L, Z, H, 32'h100, L, Z, H, H);
        check_state("fetch_wait", ARB_WAIT_I);
        cyc("fetch_busy", L, Z, L, Z, L, Z, H, L, Z, L, Z, L, Z, L, L);
        cyc("fetch_resp", L, Z, L, Z, L, Z, H, H, mdat(32'h100), L, Z, L, Z, H, H);
        check_state("fetch_idle", ARB_IDLE);

        // collision: data write wins, fetch granted on the ack cycle
        sb_push(OWNER_D, WACK);
        cyc("coll_grant_d", H, 32'h200, H, 32'h2000, H, 32'hDEAD_BEEF, H, L, Z,
            H, 32'h2000, H, 32'hDEAD_BEEF, L, H);
        check_state("coll_wait_d", ARB_WAIT_D);
        cyc("coll_wait", H, 32'h200, L, Z, L, Z, H, L, Z, L, Z, L, Z, L, L);
        sb_push(OWNER_I, mdat(32'h200));
        cyc("coll_ack_grant_i", H, 32'h200, L, Z, L, Z, H, H, WACK, H, 32'h200, L, Z, H, H);
        check_state("coll_wait_i", ARB_WAIT_I);
        cyc("coll_fetch_resp", L, Z, L, Z, L, Z, H, H, mdat(32'h200), L, Z, L, Z, H, H);
        check_state("coll_idle", ARB_IDLE);

        // back-to-back fetches, latency 1
        sb_push(OWNER_I, mdat(32'h0));
        cyc("b2b_0", H, 32'h0, L, Z, L, Z, H, L, Z, H, 32'h0, L, Z, H, H);
        sb_push(OWNER_I, mdat(32'h4));
        cyc("b2b_4", H, 32'h4, L, Z, L, Z, H, H, mdat(32'h0), H, 32'h4, L, Z, H, H);
        sb_push(OWNER_I, mdat(32'h8));
        cyc("b2b_8", H, 32'h8, L, Z, L, Z, H, H, mdat(32'h4), H, 32'h8, L, Z, H, H);
        cyc("b2b_drain", L, Z, L, Z, L, Z, H, H, mdat(32'h8), L, Z, L, Z, H, H);
        check_state("b2b_idle", ARB_IDLE);

        // memory not ready when the response arrives
        sb_push(OWNER_I, mdat(32'h300));
        cyc("busy_issue", H, 32'h300, L, Z, L, Z, H, L, Z, H, 32'h300, L, Z, H, H);
        cyc("busy_wait", L, Z, L, Z, L, Z, H, L, Z, L, Z, L, Z, L, L);
        cyc("busy_resp", H, 32'h304, L, Z, L, Z, L, H, mdat(32'h300), L, Z, L, Z, L, L);
        check_state("busy_resp_idle", ARB_IDLE);
        cyc("busy_hold", H, 32'h304, L, Z, L, Z, L, L, Z, L, Z, L, Z, L, L);
        sb_push(OWNER_I, mdat(32'h304));
        cyc("busy_ready", H, 32'h304, L, Z, L, Z, H, L, Z, H, 32'h304, L, Z, H, H);
        cyc("busy_resp2", L, Z, L, Z, L, Z, H, H, mdat(32'h304), L, Z, L, Z, H, H);
        check_state("busy_idle", ARB_IDLE);

        // spurious responses in IDLE
        cyc("spur_idle", L, Z, L, Z, L, Z, L, H, 32'h1234_5678, L, Z, L, Z, L, L);
        check_state("spur_state", ARB_IDLE);
        cyc("spur_ready", L, Z, L, Z, L, Z, H, H, 32'h8765_4321, L, Z, L, Z, H, H);
        check_state("spur_state2", ARB_IDLE);

        // reset while a data read is outstanding
        cyc("rmf_grant_d", L, Z, H, 32'h40, L, Z, H, L, Z, H, 32'h40, L, Z, L, H);
        check_state("rmf_wait_d", ARB_WAIT_D);
        rst = H;
        cyc("rmf_in_reset", H, 32'h44, H, 32'h48, H, 32'h1, H, H, 32'h55, L, Z, L, Z, L, L);
        check_state("rmf_reset_state", ARB_IDLE);
        rst = L;
        cyc("rmf_late_resp", L, Z, L, Z, L, Z, L, H, 32'h66, L, Z, L, Z, L, L);
        sb_push(OWNER_I, mdat(32'h500));
        cyc("rmf_fetch", H, 32'h500, L, Z, L, Z, H, L, Z, H, 32'h500, L, Z, H, H);
        cyc("rmf_resp", L, Z, L, Z, L, Z, H, H, mdat(32'h500), L, Z, L, Z, H, H);
        check_state("rmf_idle", ARB_IDLE);

        cyc("tail", L, Z, L, Z, L, Z, H, L, Z, L, Z, L, Z, H, H);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d responses outstanding, want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
